gcc_sched: RTL and testbench
============================

Name: gcc_sched

Overview:
Sequencing controller for the weighted geometric-centre datapath. It owns the 6-entry point store and time-shares one 8x8 multiplier and one restoring divider across the distance, summation and division phases. It accepts points over a valid/accept handshake. Once the store is full, each new point replaces the stored point farthest from the current centre. It publishes Xc/Yc with a READY flag.

Parameters:
NPTS, 6, number of point slots (the design is verified at 6 only)
CW, 8, coordinate width for X, Y, Xc, Yc
WW, 4, weight width

Ports:
CLK     in   1    clock, rising edge
RESET   in   1    asynchronous, active-low reset
VALID   in   1    X/Y/W hold a point this cycle
ACCEPT  out  1    point consumed on any edge where VALID and ACCEPT are both 1
X       in   8    point x coordinate
Y       in   8    point y coordinate
W       in   4    point weight; 0 means the point is discarded
READY   out  1    Xc/Yc are valid for the current store contents
BUSY    out  1    sequencer is not in IDLE
Xc      out  8    weighted centre, x
Yc      out  8    weighted centre, y

Behaviour:
Reset:
- RESET low, asynchronous: slots x/y/w = 0, count = 0, Xc = Yc = 0, READY = 0, state = IDLE.
- Reset mid-operation aborts all work. No partial result is ever published.

Outputs:
- ACCEPT = (state == IDLE), combinational.
- BUSY = !ACCEPT.

Point intake (in IDLE):
- VALID & W == 0: handshake completes, no state change, READY unchanged.
- VALID & W != 0: latch point into pending register, clear READY.
  - count < NPTS: write pending to slot[count], count++, go to SUM.
  - count == NPTS: go to DIST.

State machine (IDLE, DIST, SEL, SUM, DIV, DONE):
- DIST, 12 cycles, 2 per slot k = 0..5:
  - cycle a: acc = dx*dx; cycle b: acc += dy*dy.
  - dx = |x[k] - Xc|, dy = |y[k] - Yc|, 8-bit; d is 17-bit.
  - Running argmax updates only on strictly greater d, so ties go to the lowest index.
- SEL, 1 cycle: slot[argmax] <= pending.
- SUM, 6 cycles, one slot per cycle:
  - SUMXW += x*w and SUMYW += y*w, 15-bit each.
  - SUMW += w, 7-bit.
  - All accumulators are cleared on SUM entry.
- DIV, 16 cycles:
  - 8 restoring-division steps for SUMXW/SUMW, then 8 for SUMYW/SUMW.
  - Quotient is floor, 8-bit; a weighted mean never exceeds 255.
  - Divisor is never 0 because stored weights are nonzero.
- DONE, 1 cycle: Xc/Yc registered from the quotients, READY = 1, go to IDLE.

Latency (edges after the accepting edge until READY = 1 and ACCEPT = 1):
- Store not yet full: 23.
- Store full: 36.

Hold behaviour:
- Xc/Yc hold their old values from acceptance until DONE. Consumers qualify them with READY.
- Slot contents change only in IDLE (fill) or SEL.

Optional Feature:
GCC_DUP_FILTER_EN
- Defined: a VALID point whose X, Y and W all equal the most recently written slot is consumed and ignored. There is no state change and READY stays set. This comparison is not made after reset until the first write.
- Undefined: duplicates are processed like any other point.

Test Plan:
1. Single point (10,20,3) after reset -> READY rises 23 edges after accept; Xc = 10, Yc = 20; count = 1.
2. Points (0,0,1) then (100,200,3), each sent after READY -> Xc = 75, Yc = 150.
3. VALID with W = 0 (5,5,0) in IDLE -> ACCEPT handshake completes; BUSY stays 0; READY and Xc/Yc unchanged; count unchanged.
4. Fill with (10,10,1), (20,20,1), (30,30,1), (40,40,1), (50,50,1), (200,200,1):
   - After the sixth point, Xc = Yc = 58.
   - Then send (60,60,1): slot5 is replaced; READY 36 edges after accept; Xc = Yc = 35.
5. Fill six points of (100,100,2), then send (0,0,1):
   - All d = 0, so slot0 is replaced (lowest index).
   - Xc = Yc = floor(1000/11) = 90.
6. Pull RESET low during DIV of scenario 4 -> READY = 0, Xc = Yc = 0, ACCEPT = 1 immediately. A following point (7,9,1) yields Xc = 7, Yc = 9.

Source files
------------

// File: rtl/gcc_sched.sv
// Weighted geometric-centre sequencer: 6-slot point store, shared multiplier and restoring divider.
// Optional build macro GCC_DUP_FILTER_EN drops a point identical to the most recently written slot.
module gcc_sched #(
  parameter int NPTS = 6,
  parameter int CW   = 8,
  parameter int WW   = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          VALID,
  output logic          ACCEPT,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic [WW-1:0] W,
  output logic          READY,
  output logic          BUSY,
  output logic [CW-1:0] Xc,
  output logic [CW-1:0] Yc
);

  localparam int IW   = $clog2(NPTS);
  localparam int CNTW = $clog2(NPTS + 1);
  localparam int CTW  = $clog2((2 * CW > 2 * NPTS) ? 2 * CW : 2 * NPTS);
  localparam int WSW  = WW + $clog2(NPTS);
  localparam int SW   = CW + WSW;
  localparam int DW   = 2 * CW + 1;

  typedef enum logic [2:0] {S_IDLE, S_DIST, S_SEL, S_SUM, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CTW-1:0]  cnt_q;
  logic [CNTW-1:0] count_q;
  logic [CW-1:0]   x_q [NPTS];
  logic [CW-1:0]   y_q [NPTS];
  logic [WW-1:0]   w_q [NPTS];
  logic [CW-1:0]   pend_x_q, pend_y_q;
  logic [WW-1:0]   pend_w_q;
  logic [DW-1:0]   acc_q, max_q;
  logic [IW-1:0]   arg_q;
  logic [SW-1:0]   sumxw_q, sumyw_q;
  logic [WSW-1:0]  sumw_q;
  logic [WSW-1:0]  rem_q;
  logic [CW-1:0]   low_q, quot_q, qx_q;
  logic [CW-1:0]   xc_q, yc_q;
  logic            ready_q;

  logic            full, take, dup_hit;
  logic            wr_en;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [CW-1:0]   wr_x, wr_y, rd_x, rd_y, dx, dy, mul_a, mul_b;
  logic [WW-1:0]   wr_w, rd_w;
  logic [2*CW-1:0] prod;
  logic [CW+WW-1:0] prod_yw;
  logic [DW-1:0]   dist_sum;
  logic [WSW-1:0]  src_rem;
  logic [CW-1:0]   src_low;
  logic [WSW:0]    trial;
  logic            q_bit;

  assign ACCEPT = (state_q == S_IDLE);
  assign BUSY   = !ACCEPT;
  assign READY  = ready_q;
  assign Xc     = xc_q;
  assign Yc     = yc_q;

  assign full = (count_q == CNTW'(NPTS));
  assign take = ACCEPT && VALID && (W != '0) && !dup_hit;

`ifdef GCC_DUP_FILTER_EN
  logic          last_ok_q;
  logic [CW-1:0] last_x_q, last_y_q;
  logic [WW-1:0] last_w_q;

  assign dup_hit = last_ok_q && (X == last_x_q) && (Y == last_y_q) && (W == last_w_q);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_ok_q <= 1'b0;
      last_x_q  <= '0;
      last_y_q  <= '0;
      last_w_q  <= '0;
    end else if (wr_en) begin
      last_ok_q <= 1'b1;
      last_x_q  <= wr_x;
      last_y_q  <= wr_y;
      last_w_q  <= wr_w;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CTW'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (take) state_d = full ? S_DIST : S_SUM;
      S_DIST: if (cnt_q == CTW'(2 * NPTS - 1)) state_d = S_SEL;
      S_SEL:  state_d = S_SUM;
      S_SUM:  if (cnt_q == CTW'(NPTS - 1)) state_d = S_DIV;
      S_DIV:  if (cnt_q == CTW'(2 * CW - 1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = IW'(count_q);
    wr_x   = X;
    wr_y   = Y;
    wr_w   = W;
    if (take && !full) begin
      wr_en = 1'b1;
    end else if (state_q == S_SEL) begin
      wr_en  = 1'b1;
      wr_idx = arg_q;
      wr_x   = pend_x_q;
      wr_y   = pend_y_q;
      wr_w   = pend_w_q;
    end
  end

  // Distance walks two cycles per slot; summation walks one cycle per slot.
  assign rd_idx = (state_q == S_DIST) ? IW'(cnt_q >> 1) : IW'(cnt_q);
  assign rd_x   = x_q[rd_idx];
  assign rd_y   = y_q[rd_idx];
  assign rd_w   = w_q[rd_idx];
  assign dx     = (rd_x >= xc_q) ? rd_x - xc_q : xc_q - rd_x;
  assign dy     = (rd_y >= yc_q) ? rd_y - yc_q : yc_q - rd_y;

  always_comb begin
    mul_a = rd_x;
    mul_b = CW'(rd_w);
    if (state_q == S_DIST) begin
      mul_a = cnt_q[0] ? dy : dx;
      mul_b = cnt_q[0] ? dy : dx;
    end
  end

  assign prod     = (2 * CW)'(mul_a) * (2 * CW)'(mul_b);
  assign prod_yw  = (CW + WW)'(rd_y) * (CW + WW)'(rd_w);
  assign dist_sum = acc_q + DW'(prod);

  // Restoring divider: x quotient in steps 0..CW-1, y quotient in steps CW..2*CW-1.
  always_comb begin
    src_rem = rem_q;
    src_low = low_q;
    if (cnt_q == '0) begin
      src_rem = sumxw_q[SW-1:CW];
      src_low = sumxw_q[CW-1:0];
    end else if (cnt_q == CTW'(CW)) begin
      src_rem = sumyw_q[SW-1:CW];
      src_low = sumyw_q[CW-1:0];
    end
  end

  assign trial = {src_rem, src_low[CW-1]};
  assign q_bit = (trial >= {1'b0, sumw_q});

  // NOTE: the slot store is reset like ordinary flops because its cleared state is architecturally visible.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NPTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (wr_en) begin
      x_q[wr_idx] <= wr_x;
      y_q[wr_idx] <= wr_y;
      w_q[wr_idx] <= wr_w;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q  <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      pend_w_q <= '0;
      acc_q    <= '0;
      max_q    <= '0;
      arg_q    <= '0;
      sumxw_q  <= '0;
      sumyw_q  <= '0;
      sumw_q   <= '0;
      rem_q    <= '0;
      low_q    <= '0;
      quot_q   <= '0;
      qx_q     <= '0;
      xc_q     <= '0;
      yc_q     <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (take) begin
        pend_x_q <= X;
        pend_y_q <= Y;
        pend_w_q <= W;
        ready_q  <= 1'b0;
        max_q    <= '0;
        arg_q    <= '0;
        if (!full) count_q <= count_q + CNTW'(1);
      end

      if (state_q == S_DIST) begin
        if (!cnt_q[0]) begin
          acc_q <= DW'(prod);
        end else if (dist_sum > max_q) begin
          max_q <= dist_sum;
          arg_q <= IW'(cnt_q >> 1);
        end
      end

      if (state_q == S_SUM) begin
        sumxw_q <= sumxw_q + SW'(prod);
        sumyw_q <= sumyw_q + SW'(prod_yw);
        sumw_q  <= sumw_q + WSW'(rd_w);
      end else if (state_d == S_SUM) begin
        sumxw_q <= '0;
        sumyw_q <= '0;
        sumw_q  <= '0;
      end

      if (state_q == S_DIV) begin
        rem_q  <= q_bit ? WSW'(trial - {1'b0, sumw_q}) : WSW'(trial);
        low_q  <= src_low << 1;
        quot_q <= {quot_q[CW-2:0], q_bit};
        if (cnt_q == CTW'(CW - 1)) qx_q <= {quot_q[CW-2:0], q_bit};
      end

      if (state_q == S_DONE) begin
        xc_q    <= qx_q;
        yc_q    <= quot_q;
        ready_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gcc_sched.sv
// Directed bench for gcc_sched: expected centres and latencies are queued at send time
// and compared when READY rises.
module tb_gcc_sched;

  logic       CLK = 1'b0;
  logic       RESET, VALID, ACCEPT, READY, BUSY;
  logic [7:0] X, Y, Xc, Yc;
  logic [3:0] W;

  typedef struct {
    int xc;
    int yc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   held_x   = 0;
  int   held_y   = 0;

  gcc_sched dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .VALID  (VALID),
    .ACCEPT (ACCEPT),
    .X      (X),
    .Y      (Y),
    .W      (W),
    .READY  (READY),
    .BUSY   (BUSY),
    .Xc     (Xc),
    .Yc     (Yc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(READY),  0);
    check({tag, "_xc"},     32'(Xc),     0);
    check({tag, "_yc"},     32'(Yc),     0);
    check({tag, "_accept"}, 32'(ACCEPT), 1);
    check({tag, "_busy"},   32'(BUSY),   0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    VALID = 1'b0;
    RESET = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge CLK);
    RESET  = 1'b1;
    held_x = 0;
    held_y = 0;
  endtask

  task automatic drive_point(input int x, input int y, input int w, input string tag);
    @(negedge CLK);
    VALID = 1'b1;
    X     = 8'(x);
    Y     = 8'(y);
    W     = 4'(w);
    check({tag, "_accept_before"}, 32'(ACCEPT), 1);
    @(posedge CLK);
    #1;
    VALID = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    exp_t e;
    int   edges;
    check({tag, "_ready_cleared"}, 32'(READY), 0);
    check({tag, "_busy"},          32'(BUSY),  1);
    check({tag, "_xc_held"},       32'(Xc),    32'(held_x));
    edges = 0;
    while (edges < 100) begin
      @(posedge CLK);
      #1;
      edges++;
      if (READY) break;
    end
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(edges),  32'(e.lat));
      check({tag, "_xc"},      32'(Xc),     32'(e.xc));
      check({tag, "_yc"},      32'(Yc),     32'(e.yc));
      check({tag, "_accept"},  32'(ACCEPT), 1);
      held_x = e.xc;
      held_y = e.yc;
    end
  endtask

  task automatic send(input int x, input int y, input int w,
                      input int exc, input int eyc, input int lat, input string tag);
    exp_t e;
    e.xc  = exc;
    e.yc  = eyc;
    e.lat = lat;
    sb.push_back(e);
    drive_point(x, y, w, tag);
    wait_result(tag);
  endtask

  task automatic fill_linear();
    send(10,  10,  1, 10, 10, 23, "fill0");
    send(20,  20,  1, 15, 15, 23, "fill1");
    send(30,  30,  1, 20, 20, 23, "fill2");
    send(40,  40,  1, 25, 25, 23, "fill3");
    send(50,  50,  1, 30, 30, 23, "fill4");
    send(200, 200, 1, 58, 58, 23, "fill5");
  endtask

  initial begin
    RESET = 1'b0;
    VALID = 1'b0;
    X     = '0;
    Y     = '0;
    W     = '0;

    // Single point after reset.
    do_reset("rst1");
    send(10, 20, 3, 10, 20, 23, "single");

    // Two weighted points.
    do_reset("rst2");
    send(0,   0,   1, 0,  0,   23, "pair_a");
    send(100, 200, 3, 75, 150, 23, "pair_b");

    // Zero weight is consumed without side effects.
    drive_point(5, 5, 0, "w0");
    check("w0_busy",  32'(BUSY),   0);
    check("w0_ready", 32'(READY),  1);
    check("w0_xc",    32'(Xc),     75);
    check("w0_yc",    32'(Yc),     150);
    repeat (3) @(posedge CLK);
    #1;
    check("w0_still_idle", 32'(ACCEPT), 1);
    check("w0_ready_kept", 32'(READY),  1);

    // Fill the store, then replace the farthest slot.
    do_reset("rst4");
    fill_linear();
    send(60, 60, 1, 35, 35, 36, "replace");

    // Equal distances: lowest index is replaced.
    do_reset("rst5");
    for (int i = 0; i < 6; i++) send(100, 100, 2, 100, 100, 23, "eq_fill");
    send(0, 0, 1, 90, 90, 36, "tie");

    // Reset during the divide phase of a replacement.
    do_reset("rst6");
    fill_linear();
    drive_point(60, 60, 1, "abort");
    repeat (24) @(posedge CLK);
    #1;
    check("abort_busy_in_div", 32'(BUSY), 1);
    RESET = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    @(negedge CLK);
    RESET  = 1'b1;
    held_x = 0;
    held_y = 0;
    send(7, 9, 1, 7, 9, 23, "after_abort");

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
